// File: rtl/decoder_burst_seq.sv
// Burst chip-select sequencer: accepts base/length/stride bursts and emits one registered one-hot bank select per beat.
// Optional broadcast bursts (all banks selected) are enabled with `define DECODER_BURST_BCAST_EN.
module decoder_burst_seq #(
    parameter int unsigned N  = 32,
    parameter int unsigned LW = 8,
    localparam int unsigned A = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [A-1:0]  req_addr,
    input  logic [LW-1:0] req_len,
    input  logic [A-1:0]  req_stride,
`ifdef DECODER_BURST_BCAST_EN
    input  logic          req_bcast,
`endif
    input  logic          stall,
    output logic [N-1:0]  csel,
    output logic [A-1:0]  cur_addr,
    output logic          beat_valid,
    output logic          beat_last,
    output logic          busy,
    output logic          err
);

    localparam int unsigned AW = A + 1;
    localparam logic [AW-1:0] NW = AW'(N);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_n;
    logic [LW-1:0] cnt, cnt_n;
    logic [A-1:0]  stride, stride_n;
    logic [A-1:0]  cur_addr_n;
    logic [N-1:0]  csel_n;
    logic          beat_valid_n, beat_last_n, err_n;
    logic [AW-1:0] sum;
    logic [A-1:0]  wrap_addr;
    logic          req_ok;
`ifdef DECODER_BURST_BCAST_EN
    logic          bcast, bcast_n;
`endif

    function automatic logic [N-1:0] onehot(input logic [A-1:0] a);
        onehot = N'(1) << a;
    endfunction

    // Modulo-N step computed one bit wider so any N (not only powers of two) wraps correctly
    always_comb begin
        sum       = {1'b0, cur_addr} + {1'b0, stride};
        wrap_addr = (sum >= NW) ? A'(sum - NW) : A'(sum);
        req_ok    = ({1'b0, req_addr} < NW) && ({1'b0, req_stride} < NW);
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            stride     <= '0;
            cur_addr   <= '0;
            csel       <= '0;
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
            err        <= 1'b0;
`ifdef DECODER_BURST_BCAST_EN
            bcast      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            stride     <= stride_n;
            cur_addr   <= cur_addr_n;
            csel       <= csel_n;
            beat_valid <= beat_valid_n;
            beat_last  <= beat_last_n;
            err        <= err_n;
`ifdef DECODER_BURST_BCAST_EN
            bcast      <= bcast_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        stride_n     = stride;
        cur_addr_n   = cur_addr;
        csel_n       = csel;
        beat_valid_n = beat_valid;
        beat_last_n  = beat_last;
        err_n        = 1'b0;
`ifdef DECODER_BURST_BCAST_EN
        bcast_n      = bcast;
`endif
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_ok) begin
                        state_n      = RUN;
                        stride_n     = req_stride;
                        cnt_n        = req_len;
                        cur_addr_n   = req_addr;
                        beat_valid_n = 1'b1;
                        beat_last_n  = (req_len == '0);
`ifdef DECODER_BURST_BCAST_EN
                        bcast_n      = req_bcast;
                        csel_n       = req_bcast ? '1 : onehot(req_addr);
`else
                        csel_n       = onehot(req_addr);
`endif
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                // Stall freezes every output, so nothing changes unless stall is low
                if (!stall) begin
                    if (cnt != '0) begin
                        cnt_n       = cnt - LW'(1);
                        cur_addr_n  = wrap_addr;
                        beat_last_n = (cnt == LW'(1));
`ifdef DECODER_BURST_BCAST_EN
                        csel_n      = bcast ? '1 : onehot(wrap_addr);
`else
                        csel_n      = onehot(wrap_addr);
`endif
                    end else begin
                        state_n      = IDLE;
                        beat_valid_n = 1'b0;
                        beat_last_n  = 1'b0;
                        csel_n       = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
